// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Instruction-fetch stage of the 16-bit CPU. It owns the program counter and
//   requests instruction words from memory over a req/ack handshake. Each
//   fetched word is passed to decode, together with its PC, through a
//   valid/ready instruction register (IR). A one-entry hold buffer catches a
//   word that returns while decode is stalled. A branch redirect reloads the PC
//   and flushes everything that is in flight.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous, active-low reset
//   en          fetch enable
//   imem_req    fetch request to instruction memory (high in REQ)
//   imem_addr   fetch address, always equal to the PC
//   imem_ack    memory returns imem_rdata this cycle
//   imem_rdata  fetched instruction word
//   br_valid    branch redirect strobe
//   br_target   branch target address
//   ir_valid    IR holds a valid instruction for decode
//   ir_data     instruction word presented to decode
//   ir_pc       address of ir_data
//   ir_ready    decode accepts the IR this cycle
module pc_fetch_unit #(
    parameter int              DATA_W   = 16,
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir_data,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              ir_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc, pc_nxt;
    logic                ir_valid_nxt;
    logic [DATA_W-1:0]   ir_data_nxt;
    logic [ADDR_W-1:0]   ir_pc_nxt;
    logic [DATA_W-1:0]   hold_data, hold_data_nxt;
    logic [ADDR_W-1:0]   hold_pc, hold_pc_nxt;

    // Program counter increment; wraps modulo 2^ADDR_W with no flag.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] p);
        return p + ADDR_W'(1);
    endfunction

    logic ir_xfer;
    logic ir_free;
    assign ir_xfer = ir_valid & ir_ready;
    assign ir_free = ~ir_valid | ir_ready;

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        ir_valid_nxt  = ir_valid;
        ir_data_nxt   = ir_data;
        ir_pc_nxt     = ir_pc;
        hold_data_nxt = hold_data;
        hold_pc_nxt   = hold_pc;

        if (br_valid) begin
            // Redirect: flush the IR, drop the hold buffer (by leaving HOLD)
            // and ignore any word arriving this cycle.
            pc_nxt       = br_target;
            ir_valid_nxt = 1'b0;
            state_nxt    = en ? REQ : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (ir_xfer) ir_valid_nxt = 1'b0;
                    if (en) state_nxt = REQ;
                end
                REQ: begin
                    if (imem_ack) begin
                        pc_nxt = pc_inc(pc);
                        if (ir_free) begin
                            ir_data_nxt  = imem_rdata;
                            ir_pc_nxt    = pc;
                            ir_valid_nxt = 1'b1;
                            state_nxt    = en ? REQ : IDLE;
                        end else begin
                            // Decode is stalled: park the word until the IR drains.
                            hold_data_nxt = imem_rdata;
                            hold_pc_nxt   = pc;
                            state_nxt     = HOLD;
                        end
                    end else if (ir_xfer) begin
                        ir_valid_nxt = 1'b0;
                    end
                end
                HOLD: begin
                    // IR is necessarily valid here; it is refilled from the
                    // hold buffer as soon as decode takes the current word.
                    if (ir_ready) begin
                        ir_data_nxt = hold_data;
                        ir_pc_nxt   = hold_pc;
                        state_nxt   = en ? REQ : IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            ir_valid  <= 1'b0;
            ir_data   <= '0;
            ir_pc     <= '0;
            hold_data <= '0;
            hold_pc   <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            ir_valid  <= ir_valid_nxt;
            ir_data   <= ir_data_nxt;
            ir_pc     <= ir_pc_nxt;
            hold_data <= hold_data_nxt;
            hold_pc   <= hold_pc_nxt;
        end
    end

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        br_valid;
    logic [15:0] br_target;
    logic        ir_valid;
    logic [15:0] ir_data;
    logic [15:0] ir_pc;
    logic        ir_ready;

    int tests_run = 0;
    int tests_failed = 0;

    // Observed / expected vectors: {imem_req, ir_valid, imem_addr, ir_data, ir_pc}
    logic [49:0] obs, exp;

    pc_fetch_unit #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .ir_valid   (ir_valid),
        .ir_data    (ir_data),
        .ir_pc      (ir_pc),
        .ir_ready   (ir_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic [15:0] d, input logic r,
                         input logic b, input logic [15:0] t);
        imem_ack   = a;
        imem_rdata = d;
        ir_ready   = r;
        br_valid   = b;
        br_target  = t;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        drive(1'b1, 16'hFFFF, 1'b1, 1'b0, 16'h0000);
        tick();
        tick();
        rst_n = 1'b1;
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        drive(1'b1, 16'hFFFF, 1'b1, 1'b0, 16'h0000);
        tick();
        tick();
        tests_run++;
        if ({imem_req, ir_valid, imem_addr} !== {1'b0, 1'b0, 16'h0000}) begin
            tests_failed++;
            $display("FAIL reset_state: got req=%b valid=%b addr=%h, want req=0 valid=0 addr=0000",
                     imem_req, ir_valid, imem_addr);
        end
        rst_n = 1'b1;
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        tick();
        tests_run++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
            tests_failed++;
            $display("FAIL reset_release: got req=%b addr=%h, want req=1 addr=0000",
                     imem_req, imem_addr);
        end
    endtask

    task automatic test_streaming();
        // Now in REQ at address 0000; memory acks every cycle.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'hA000 + 16'(i), 1'b1, 1'b0, 16'h0000);
            tick();
            obs = {imem_req, ir_valid, imem_addr, ir_data, ir_pc};
            exp = {1'b1, 1'b1, 16'(i + 1), 16'hA000 + 16'(i), 16'(i)};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL stream_%0d: got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        tick();                                   // IDLE -> REQ at 0000
        drive(1'b1, 16'hA000, 1'b1, 1'b0, 16'h0000);
        tick();                                   // A000 shown, pc=0001
        drive(1'b1, 16'hA001, 1'b0, 1'b0, 16'h0000);
        tick();                                   // A001 parked in hold
        obs = {imem_req, ir_valid, imem_addr, ir_data, ir_pc};
        exp = {1'b0, 1'b1, 16'h0002, 16'hA000, 16'h0000};
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL bp_hold: got %h want %h", obs, exp);
        end
        drive(1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0000);   // ack in HOLD is ignored
        tick();
        obs = {imem_req, ir_valid, imem_addr, ir_data, ir_pc};
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL bp_stall: got %h want %h", obs, exp);
        end
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        tick();
        obs = {imem_req, ir_valid, imem_addr, ir_data, ir_pc};
        exp = {1'b1, 1'b1, 16'h0002, 16'hA001, 16'h0001};
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL bp_release: got %h want %h", obs, exp);
        end
        tick();                                   // A001 consumed, no refill
        tests_run++;
        if ({ir_valid, imem_req} !== 2'b01) begin
            tests_failed++;
            $display("FAIL bp_drain: got valid=%b req=%b want valid=0 req=1", ir_valid, imem_req);
        end
    endtask

    task automatic test_branch();
        // In REQ at 0002, IR empty; branch collides with an ack.
        drive(1'b1, 16'hBEEF, 1'b1, 1'b1, 16'h1234);
        tick();
        obs = {imem_req, ir_valid, imem_addr, 32'h0};
        exp = {1'b1, 1'b0, 16'h1234, 32'h0};
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL br_redirect: got %h want %h", obs, exp);
        end
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        tick();
        tests_run++;
        if ({ir_valid, imem_addr} !== {1'b0, 16'h1234}) begin
            tests_failed++;
            $display("FAIL br_no_beef: got valid=%b data=%h addr=%h want valid=0 addr=1234",
                     ir_valid, ir_data, imem_addr);
        end
    endtask

    task automatic test_wrap();
        drive(1'b1, 16'h1111, 1'b1, 1'b0, 16'h0000);
        tick();                                   // IR = 1111 @ 1234
        obs = {imem_req, ir_valid, imem_addr, ir_data, ir_pc};
        exp = {1'b1, 1'b1, 16'h1235, 16'h1111, 16'h1234};
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL br_fetch: got %h want %h", obs, exp);
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF); // flush a stalled IR
        tick();
        tests_run++;
        if ({ir_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 16'hFFFF}) begin
            tests_failed++;
            $display("FAIL br_flush: got valid=%b req=%b addr=%h want valid=0 req=1 addr=ffff",
                     ir_valid, imem_req, imem_addr);
        end
        drive(1'b1, 16'hC0DE, 1'b1, 1'b0, 16'h0000);
        tick();
        obs = {imem_req, ir_valid, imem_addr, ir_data, ir_pc};
        exp = {1'b1, 1'b1, 16'h0000, 16'hC0DE, 16'hFFFF};
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL wrap: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_enable();
        // en=0 must not cancel the outstanding request at 0000.
        en = 1'b0;
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        tick();
        tests_run++;
        if ({imem_req, ir_valid, imem_addr} !== {1'b1, 1'b0, 16'h0000}) begin
            tests_failed++;
            $display("FAIL en_keep_req: got req=%b valid=%b addr=%h want req=1 valid=0 addr=0000",
                     imem_req, ir_valid, imem_addr);
        end
        drive(1'b1, 16'h7777, 1'b1, 1'b0, 16'h0000);
        tick();
        obs = {imem_req, ir_valid, imem_addr, ir_data, ir_pc};
        exp = {1'b0, 1'b1, 16'h0001, 16'h7777, 16'h0000};
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL en_to_idle: got %h want %h", obs, exp);
        end
        en = 1'b1;
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        tick();
        tests_run++;
        if ({imem_req, ir_valid, imem_addr} !== {1'b1, 1'b0, 16'h0001}) begin
            tests_failed++;
            $display("FAIL en_restart: got req=%b valid=%b addr=%h want req=1 valid=0 addr=0001",
                     imem_req, ir_valid, imem_addr);
        end
    endtask

    task automatic test_reset_mid_request();
        // In REQ at 0001 with an ack arriving together with reset.
        rst_n = 1'b0;
        drive(1'b1, 16'h5555, 1'b1, 1'b0, 16'h0000);
        tick();
        obs = {imem_req, ir_valid, imem_addr, ir_data, ir_pc};
        exp = {1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL reset_mid_req: got %h want %h", obs, exp);
        end
        rst_n = 1'b1;
        en = 1'b0;
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        tick();
        tests_run++;
        if ({imem_req, imem_addr} !== {1'b0, 16'h0000}) begin
            tests_failed++;
            $display("FAIL reset_idle: got req=%b addr=%h want req=0 addr=0000", imem_req, imem_addr);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        test_reset();
        test_streaming();
        test_back_pressure();
        test_branch();
        test_wrap();
        test_reset();
        test_enable();
        test_reset_mid_request();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
